// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_rr_arbiter
// Purpose  : Two-master Wishbone classic round-robin arbiter, one transfer per
//            grant. Optional watchdog enabled by WB_RR_ARBITER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    OWN0 = 3'b010,
    OWN1 = 3'b100
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 1 = m1 won the most recent grant
  logic   req0, req1, own0, own1, wdt_fire;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  // Ownership is masked during reset so no ack/err can leak out of that cycle.
  assign own0 = (state_q == OWN0) & ~rst;
  assign own1 = (state_q == OWN1) & ~rst;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam logic [7:0] WDT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdt_q, wdt_d;

  // wdt_q counts owned cycles already elapsed, so the TIMEOUT_CYCLES-th
  // owned cycle is the one that sees WDT_LAST.
  assign wdt_fire = (own0 | own1) & ~s_ack_i & (wdt_q == WDT_LAST);

  always_comb begin
    wdt_d = wdt_q;
    if (state_q == IDLE) begin
      wdt_d = 8'd0;
    end else if (!s_ack_i) begin
      wdt_d = wdt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q <= 8'd0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wdt_fire       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = OWN0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = OWN1;
          last_grant_d = 1'b1;
        end
      end
      OWN0: if (s_ack_i || !m0_cyc_i || wdt_fire) state_d = IDLE;
      OWN1: if (s_ack_i || !m1_cyc_i || wdt_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'd0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = own0 & wdt_fire;
  assign m1_err_o = own1 & wdt_fire;
  assign grant_o  = {own1, own0};

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_rr_arbiter
// Purpose  : Directed and randomized checks of wb_rr_arbiter against a
//            transfer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_rr_arbiter;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TO    = 4;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TO    = 255;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_adr_i = 0, m1_dat_i = 0, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [31:0] s_dat_i = 0;
  logic        s_ack_i = 0;
  logic [1:0]  grant_o;

  wb_rr_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who owns the bus (-1 idle), who won last, owned-cycle index.
  int   own     = -1;
  int   last    = 1;
  int   owned_n = 0;
  logic e_ack0, e_ack1, e_err0, e_err1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input int m, input logic c, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_sel_i = s; m0_adr_i = a; m0_dat_i = d;
    end else begin
      m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_sel_i = s; m1_adr_i = a; m1_dat_i = d;
    end
  endtask

  // Settle combinational outputs, then compare against the model.
  task automatic settle();
    logic [70:0] e_bus;
    logic        timeout;
    #1;
    e_bus   = '0;
    timeout = TO_EN && (own >= 0) && !s_ack_i && (owned_n == TO);
    if (own == 0) e_bus = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
    if (own == 1) e_bus = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
    e_ack0 = !rst && (own == 0) && s_ack_i;
    e_ack1 = !rst && (own == 1) && s_ack_i;
    e_err0 = !rst && (own == 0) && timeout;
    e_err1 = !rst && (own == 1) && timeout;
    if (!rst) begin
      chk("s_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}), 128'(e_bus));
      chk("m0_resp", 128'({m0_ack_o, m0_err_o, m0_dat_o}), 128'({e_ack0, e_err0, s_dat_i}));
      chk("m1_resp", 128'({m1_ack_o, m1_err_o, m1_dat_o}), 128'({e_ack1, e_err1, s_dat_i}));
      chk("grant", 128'(grant_o), 128'({own == 1, own == 0}));
    end
  endtask

  // Advance the model across the coming rising edge, then wait for the next falling edge.
  task automatic adv();
    logic r0, r1, ocyc;
    r0 = m0_cyc_i & m0_stb_i;
    r1 = m1_cyc_i & m1_stb_i;
    if (rst) begin
      own = -1; last = 1; owned_n = 0;
    end else if (own < 0) begin
      if (r0 && r1) own = (last == 0) ? 1 : 0;
      else if (r0)  own = 0;
      else if (r1)  own = 1;
      if (own >= 0) begin
        last    = own;
        owned_n = 1;
      end
    end else begin
      ocyc = (own == 0) ? m0_cyc_i : m1_cyc_i;
      if (s_ack_i || !ocyc || (TO_EN && owned_n == TO)) own = -1;
      else owned_n++;
    end
    @(negedge clk);
  endtask

  logic        act [2];
  logic        done_f [2];
  logic        rw [2];
  logic [3:0]  rs [2];
  logic [31:0] ra [2], rd [2];

  initial begin
    @(negedge clk);
    settle(); adv();
    settle(); adv();
    rst = 1'b0;

    // Reset state
    settle();
    chk("rst_grant", 128'(grant_o), 128'(0));
    chk("rst_scyc", 128'({s_cyc_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 128'(0));
    adv();

    // Single m0 read, slave acks on the second granted cycle
    drv(0, 1, 0, 4'hF, 32'h4000_0000, 0);
    settle(); chk("rd_grant_idle", 128'(grant_o), 128'(2'b00)); adv();
    settle(); chk("rd_grant_own", 128'(grant_o), 128'(2'b01));
    chk("rd_adr", 128'(s_adr_o), 128'(32'h4000_0000)); adv();
    s_ack_i = 1; s_dat_i = 32'h0050_0093;
    settle(); chk("rd_ack", 128'({m0_ack_o, m0_dat_o}), 128'({1'b1, 32'h0050_0093})); adv();
    s_ack_i = 0; drv(0, 0, 0, 0, 0, 0);
    settle(); chk("rd_grant_after", 128'({grant_o, m0_ack_o}), 128'(0)); adv();

    // Four ties after reset alternate 0,1,0,1
    rst = 1; settle(); adv(); rst = 0;
    drv(0, 1, 0, 4'hF, 32'h100, 0);
    drv(1, 1, 0, 4'hF, 32'h200, 0);
    for (int i = 0; i < 4; i++) begin
      s_ack_i = 0; settle(); chk("tie_idle", 128'(grant_o), 128'(0)); adv();
      s_ack_i = 1; settle();
      chk("tie_win", 128'(grant_o), 128'((i % 2 == 0) ? 2'b01 : 2'b10)); adv();
    end
    s_ack_i = 0; drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    settle(); adv();

    // m1 write forwarding; stray ack while idle must not reach either master
    drv(1, 1, 1, 4'b0011, 32'h8000_0010, 32'hCAFE_BABE);
    s_ack_i = 1;
    settle(); chk("wr_idle_acks", 128'({m0_ack_o, m1_ack_o}), 128'(0)); adv();
    settle();
    chk("wr_bus", 128'({s_we_o, s_sel_o, s_adr_o, s_dat_o}),
        128'({1'b1, 4'b0011, 32'h8000_0010, 32'hCAFE_BABE}));
    chk("wr_acks", 128'({m0_ack_o, m1_ack_o}), 128'(2'b01)); adv();
    s_ack_i = 0; drv(1, 0, 0, 0, 0, 0);
    settle(); adv();

    // Abort by m0 with m1 pending
    drv(0, 1, 0, 4'hF, 32'h300, 0);
    drv(1, 1, 0, 4'hF, 32'h400, 0);
    settle(); adv();
    settle(); chk("ab_grant0", 128'(grant_o), 128'(2'b01)); adv();
    drv(0, 0, 0, 0, 0, 0);
    settle(); chk("ab_noresp", 128'({m0_ack_o, m0_err_o, s_cyc_o}), 128'(0)); adv();
    settle(); chk("ab_idle", 128'(grant_o), 128'(0)); adv();
    settle(); chk("ab_grant1", 128'(grant_o), 128'(2'b10)); adv();
    s_ack_i = 1; settle(); adv();
    s_ack_i = 0; drv(1, 0, 0, 0, 0, 0);
    settle(); adv();

    // Reset while m1 owns the bus
    drv(1, 1, 0, 4'hF, 32'h500, 0);
    settle(); adv();
    settle(); chk("mr_own1", 128'(grant_o), 128'(2'b10)); adv();
    rst = 1; settle(); adv();
    rst = 0; s_ack_i = 1;
    drv(0, 1, 0, 4'hF, 32'h600, 0);
    settle(); chk("mr_out", 128'({s_cyc_o, grant_o, m1_ack_o, m1_err_o}), 128'(0)); adv();
    s_ack_i = 0;
    settle(); chk("mr_tie", 128'(grant_o), 128'(2'b01)); adv();
    s_ack_i = 1; settle(); adv();
    s_ack_i = 0; drv(0, 0, 0, 0, 0, 0); drv(1, 0, 0, 0, 0, 0);
    settle(); adv();

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    // Stalled slave: err on the 4th owned cycle only; then ack on the 4th wins
    drv(0, 1, 0, 4'hF, 32'h700, 0);
    settle(); adv();
    for (int k = 1; k <= 4; k++) begin
      settle(); chk("wd_err", 128'(m0_err_o), 128'(k == 4)); adv();
    end
    settle(); chk("wd_grant_after", 128'(grant_o), 128'(0)); adv();
    for (int k = 1; k <= 4; k++) begin
      s_ack_i = (k == 4);
      settle(); chk("wd2_resp", 128'({m0_ack_o, m0_err_o}), 128'({k == 4, 1'b0})); adv();
    end
    s_ack_i = 0; drv(0, 0, 0, 0, 0, 0);
    settle(); adv();
`endif

    // Randomized traffic
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; done_f[m] = 0; rw[m] = 0; rs[m] = 0; ra[m] = 0; rd[m] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (act[m] && (done_f[m] || ($urandom % 25 == 0))) begin
          act[m] = 0;
        end else if (!act[m] && ($urandom % 3 == 0)) begin
          act[m] = 1;
          rw[m]  = 1'($urandom);
          rs[m]  = 4'($urandom);
          ra[m]  = $urandom;
          rd[m]  = $urandom;
        end
        drv(m, act[m], rw[m], rs[m], ra[m], rd[m]);
      end
      s_ack_i = ($urandom % 3 == 0);
      s_dat_i = $urandom;
      rst     = ($urandom % 300 == 0);
      settle();
      done_f[0] = e_ack0 | e_err0;
      done_f[1] = e_ack1 | e_err1;
      adv();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
